// File: rtl/i2s_dsp_rx_pkg.sv
// Shared types and sizing constants for the DSP-mode serial receive deserializer.
package i2s_dsp_rx_pkg;

    localparam int BIT_CNT_W      = 5;
    localparam int WORD_CNT_W     = 4;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        ARM,
        RECV
    } state_e;

endpackage

// File: rtl/i2s_dsp_rx_outbuf.sv
// Single-entry valid/ready holding register; a word arriving while full and stalled
// is dropped and flagged in a sticky overflow bit.
module i2s_dsp_rx_outbuf
    import i2s_dsp_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [WORD_CNT_W-1:0] wr_idx_i,
    input  logic                  rd_ready_i,
    output logic [DATA_W-1:0]     data_o,
    output logic [WORD_CNT_W-1:0] idx_o,
    output logic                  valid_o,
    output logic                  overflow_o
);

    logic [DATA_W-1:0]     data_q, data_d;
    logic [WORD_CNT_W-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (wr_en_i) begin
            // A consumer accepting this cycle frees the slot for the incoming word.
            if (!valid_q || rd_ready_i) begin
                data_d  = wr_data_i;
                idx_d   = wr_idx_i;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && rd_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign idx_o      = idx_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/i2s_dsp_rx_deser.sv
// DSP-mode (single-pulse frame sync) serial receive deserializer.
// Optional macro I2S_DSP_RX_SYNC_CHECK_EN: flag and resynchronise on unexpected ws pulses.
module i2s_dsp_rx_deser
    import i2s_dsp_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  sck_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [BIT_CNT_W-1:0]  cfg_num_bits_i,
    input  logic [WORD_CNT_W-1:0] cfg_num_words_i,
    input  logic                  cfg_ws_delay_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    output logic [DATA_W-1:0]     data_o,
    output logic [WORD_CNT_W-1:0] data_word_idx_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  overflow_o,
    output logic                  sync_err_o
);

    state_e                state_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [WORD_CNT_W-1:0] word_cnt_q;
    logic [BIT_CNT_W-1:0]  nbits_q;
    logic [WORD_CNT_W-1:0] nwords_q;
    logic                  delay_q;
    logic [DATA_W-1:0]     shift_q;

    logic                  frame_start;
    logic                  sample;
    logic [BIT_CNT_W-1:0]  cur_bit;
    logic [WORD_CNT_W-1:0] cur_word;
    logic [BIT_CNT_W-1:0]  nb;
    logic [WORD_CNT_W-1:0] nw;
    logic                  delay_eff;
    logic [DATA_W-1:0]     shift_nx;
    logic                  last_bit;
    logic                  last_word;
    logic                  word_done;
    logic                  frame_done;
`ifdef I2S_DSP_RX_SYNC_CHECK_EN
    logic                  legal_slot;
    logic                  restart;
`endif

    // Decode what happens to this cycle's sd bit; a frame start uses the live cfg values.
    always_comb begin
        frame_start = 1'b0;
        sample      = 1'b0;
        cur_bit     = bit_cnt_q;
        cur_word    = word_cnt_q;
        nb          = nbits_q;
        nw          = nwords_q;
        delay_eff   = delay_q;
        case (state_q)
            HUNT: frame_start = ws_i;
            ARM: begin
                sample   = 1'b1;
                cur_bit  = '0;
                cur_word = '0;
            end
            RECV:    sample = 1'b1;
            default: ;
        endcase
`ifdef I2S_DSP_RX_SYNC_CHECK_EN
        legal_slot = delay_q && (bit_cnt_q == nbits_q) && (word_cnt_q == nwords_q);
        restart    = (state_q == RECV) && ws_i && !legal_slot;
        if (restart) begin
            frame_start = 1'b1;
        end
`endif
        if (frame_start) begin
            nb        = cfg_num_bits_i;
            nw        = cfg_num_words_i;
            delay_eff = cfg_ws_delay_i;
            cur_bit   = '0;
            cur_word  = '0;
            sample    = !cfg_ws_delay_i;
        end
        if (cur_bit == '0) begin
            shift_nx = {{(DATA_W-1){1'b0}}, sd_i};
        end else begin
            shift_nx = {shift_q[DATA_W-2:0], sd_i};
        end
        last_bit   = (cur_bit == nb);
        last_word  = (cur_word == nw);
        word_done  = sample && last_bit;
        frame_done = word_done && last_word;
    end

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            nbits_q    <= '0;
            nwords_q   <= '0;
            delay_q    <= 1'b0;
        end else if (!cfg_en_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= HUNT;
                default: begin
                    if (frame_start) begin
                        nbits_q  <= cfg_num_bits_i;
                        nwords_q <= cfg_num_words_i;
                        delay_q  <= cfg_ws_delay_i;
                    end
                    if (frame_start && cfg_ws_delay_i) begin
                        state_q    <= ARM;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                    end else if (sample) begin
                        if (frame_done) begin
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                            // With delayed data, a pulse on the final bit opens the next frame.
                            if (delay_eff && ws_i) begin
                                state_q  <= ARM;
                                nbits_q  <= cfg_num_bits_i;
                                nwords_q <= cfg_num_words_i;
                            end else begin
                                state_q <= HUNT;
                            end
                        end else if (last_bit) begin
                            state_q    <= RECV;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= cur_word + 1'b1;
                        end else begin
                            state_q    <= RECV;
                            bit_cnt_q  <= cur_bit + 1'b1;
                            word_cnt_q <= cur_word;
                        end
                    end
                end
            endcase
        end
    end

    // Every word start overwrites the whole register, so no reset is needed here.
    always_ff @(posedge sck_i) begin
        if (sample) begin
            shift_q <= shift_nx;
        end
    end

`ifdef I2S_DSP_RX_SYNC_CHECK_EN
    logic sync_err_q;

    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            sync_err_q <= 1'b0;
        end else if (!cfg_en_i) begin
            sync_err_q <= 1'b0;
        end else if (restart) begin
            sync_err_q <= 1'b1;
        end
    end

    assign sync_err_o = sync_err_q;
`else
    assign sync_err_o = 1'b0;
`endif

    i2s_dsp_rx_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk_i      (sck_i),
        .rst_i      (rst_i),
        .clr_i      (!cfg_en_i),
        .wr_en_i    (word_done && cfg_en_i),
        .wr_data_i  (shift_nx),
        .wr_idx_i   (cur_word),
        .rd_ready_i (data_ready_i),
        .data_o     (data_o),
        .idx_o      (data_word_idx_o),
        .valid_o    (data_valid_o),
        .overflow_o (overflow_o)
    );

endmodule

// File: doc/i2s_dsp_rx_deser.md
Name: i2s_dsp_rx_deser

Overview:
DSP-mode (single-pulse frame sync) serial receive deserializer. It sits downstream of the DSP word-select generator, on the same serial clock. It consumes the one-cycle ws pulse and the sd line, and assembles each frame of (cfg_num_bits_i+1)-bit words, (cfg_num_words_i+1) words per frame, into parallel words. Words go out through a one-entry valid/ready buffer to the RX FIFO / clock-domain crossing.

Parameters:
DATA_W, 32, output word width; words longer than DATA_W keep the last DATA_W bits received.

Ports:
sck_i  in  1  serial clock; all logic on posedge.
rst_i  in  1  asynchronous active-high reset.
cfg_en_i  in  1  receiver enable.
cfg_num_bits_i  in  5  bits per word minus 1.
cfg_num_words_i  in  4  words per frame minus 1.
cfg_ws_delay_i  in  1  0: first data bit in the ws pulse cycle; 1: first data bit one cycle after the pulse.
ws_i  in  1  frame-sync pulse, high for one sck cycle.
sd_i  in  1  serial data, MSB first.
data_o  out  DATA_W  received word, right-justified, zero-extended.
data_word_idx_o  out  4  word index within frame of data_o.
data_valid_o  out  1  word available.
data_ready_i  in  1  consumer accepts word.
overflow_o  out  1  sticky: a word was dropped.
sync_err_o  out  1  sticky: unexpected ws (see Optional Feature).

Behaviour:
- Reset values: data_o=0, data_word_idx_o=0, data_valid_o=0, overflow_o=0, sync_err_o=0, state=IDLE, all counters 0.
- States:
  - IDLE: cfg_en_i=1 -> HUNT.
  - HUNT: on ws_i=1, latch cfg_num_bits_i, cfg_num_words_i and cfg_ws_delay_i for the whole frame.
    - delay=0: sample sd_i as bit 0 in this same cycle, go to RECV.
    - delay=1: go to ARM.
  - ARM: sample bit 0 and go to RECV.
  - RECV: shift in one bit per cycle using bit_cnt (5b) and word_cnt (4b).
    - On the last bit of a word: bit_cnt -> 0, word_cnt++.
    - On the last bit of the last word: if delay=1 and ws_i=1 this cycle -> ARM (back-to-back frames, no gap); otherwise -> HUNT.
- Shift register: shift_q <= {shift_q[DATA_W-2:0], sd_i}. It is cleared at each word start, so the first bit lands as the MSB of the right-justified result.
- 1-bit words (num_bits=0): every sampled bit completes a word.
- Frame with num_bits=0 and num_words=0 under delay=0: completes in the HUNT cycle and stays in HUNT.
- Word completion: data_o, data_word_idx_o and data_valid_o are registered one cycle after the last bit is sampled.
- Output buffer:
  - Word completes while data_valid_o=1 and data_ready_i=0: the new word is dropped, the old one is held, overflow_o is set.
  - data_ready_i=1 in the same cycle: the new word replaces the old one, no overflow.
  - Handshake complete and no new word: data_valid_o -> 0.
- ws_i high in RECV, other than the legal delay=1 last-bit case: ignored unless the feature is enabled.
- cfg_en_i=0 in any state:
  - next cycle state=IDLE, counters 0, partial word discarded.
  - data_valid_o, overflow_o and sync_err_o cleared.
  - ws_i and sd_i are ignored.
- Config changes take effect only at the next frame start.

Optional Feature:
I2S_DSP_RX_SYNC_CHECK_EN:
- Defined: ws_i=1 in RECV at any cycle other than the legal last-bit/delay=1 slot sets sync_err_o (sticky until cfg_en_i=0). The partial word is discarded and the frame restarts from this pulse using the current cfg_* values (delay=0: this cycle's bit is bit 0; delay=1: ARM). Words already delivered are unaffected.
- Undefined: sync_err_o tied 0 and unexpected pulses are ignored.

Decomposition:
- Package i2s_dsp_rx_pkg:
  - state enum {IDLE, HUNT, ARM, RECV};
  - constants BIT_CNT_W=5, WORD_CNT_W=4, default DATA_W.
- One sub-module, i2s_dsp_rx_outbuf: single-entry valid/ready holding register with drop-on-full and sticky overflow.

Test Plan:
1. num_bits=7, num_words=1, delay=0; ws at cycle 0; sd = 0xA5 then 0x3C MSB-first from cycle 0 -> 0x000000A5 (idx0) valid at cycle 8, 0x0000003C (idx1) valid at cycle 16; ready=1 throughout.
2. delay=1, same sizes, next ws in the last-bit cycle 16, frames back-to-back -> four words, no gap, no sync_err.
3. ready=0 across two frames of scenario 1 -> data_o holds 0xA5, overflow_o=1 from cycle 16; ready=1 -> valid drops next cycle.
4. num_bits=0, num_words=0, delay=0, ws every cycle, sd alternating 1,0 -> words 1,0,1,... each valid one cycle after the sample.
5. cfg_en_i dropped at cycle 5 of a frame -> valid=0, no word output; re-enable with ws -> clean frame received.
6. With I2S_DSP_RX_SYNC_CHECK_EN, num_bits=7, ws re-asserted at cycle 4 -> sync_err_o=1, 8 bits from cycle 4 form word idx0.
